// File: rtl/load_store_unit_if.sv
// Request/response handshake between the MEM stage and the load/store unit,
// plus the word-wide data-memory port the unit drives.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  // MEM-stage side: issues requests, consumes responses.
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  // Load/store unit: serves requests and drives the data memory.
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_addr, mem_wdata, mem_write, mem_read,
    input  mem_rdata
  );

  // Data memory: combinational read, write committed on the negedge.
  modport mem (
    input  mem_addr, mem_wdata, mem_write, mem_read,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// MIPS MEM-stage load/store unit: byte/half/word accesses to a little-endian
// word memory, sub-word stores by read-modify-write, alignment/range checking.
module load_store_unit #(
  parameter int MEM_BYTES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state_q, state_d;
  logic        we_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, word_q;

  logic        accept, acc_err, bad_shape;
  logic [2:0]  nbytes_m1;
  logic [32:0] last_byte;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] merged, load_ext;

  assign accept = bus.req_valid && (state_q == IDLE);

  // Request legality, evaluated on the raw request in the accepting cycle.
  always_comb begin
    // NOTE: every variable gets a default before the case so no latch is inferred.
    bad_shape = 1'b0;
    nbytes_m1 = 3'd0;
    case (bus.req_size)
      SZ_BYTE: nbytes_m1 = 3'd0;
      SZ_HALF: begin
        nbytes_m1 = 3'd1;
        bad_shape = bus.req_addr[0];
      end
      SZ_WORD: begin
        nbytes_m1 = 3'd3;
        bad_shape = |bus.req_addr[1:0];
      end
      default: bad_shape = 1'b1;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    last_byte = {1'b0, bus.req_addr} + {30'd0, nbytes_m1};
    acc_err   = bad_shape || (last_byte >= 33'(MEM_BYTES));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (acc_err)                       state_d = RESP;
          else if (!bus.req_we)              state_d = RD;
          else if (bus.req_size == SZ_WORD)  state_d = WR;
          else                               state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state and registered request only.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.mem_read   = (state_q == RD);
    bus.mem_write  = (state_q == WR);
    bus.mem_addr   = ((state_q == RD) || (state_q == WR)) ? {addr_q[31:2], 2'b00} : 32'd0;
    bus.mem_wdata  = (state_q == WR) ? merged : 32'd0;
    bus.resp_valid = (state_q == RESP);
    bus.resp_error = (state_q == RESP) && err_q;
    bus.resp_rdata = ((state_q == RESP) && !we_q && !err_q) ? load_ext : 32'd0;
  end

  // Latched request and captured memory word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the captured word is a single register, not a memory array, so it is reset too.
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      word_q  <= 32'd0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        err_q   <= acc_err;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == RD) word_q <= bus.mem_rdata;
    end
  end

  // Store merge: sub-word data replaces its lanes in the captured word.
  always_comb begin
    merged = word_q;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  // Load extraction and extension.
  always_comb begin
    lane_b = word_q[{addr_q[1:0], 3'b000} +: 8];
    lane_h = word_q[{addr_q[1], 4'b0000} +: 16];
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: load_ext = uns_q ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = word_q;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: 32-byte memory model, per-transaction
// cycle trace, immediate-assertion checks and a one-line summary.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Data memory: 8 words, combinational read, write on negedge.
  logic [31:0] mem [8];
  assign bus.mem_rdata = mem[bus.mem_addr[4:2]];
  always @(negedge clk) if (bus.mem_write) mem[bus.mem_addr[4:2]] <= bus.mem_wdata;

  int checks   = 0;
  int failures = 0;

  // Per-transaction trace.
  int          lat, n_rd, n_wr, rd_cyc, wr_cyc;
  logic [31:0] wr_data, wr_addr, rsp_data;
  logic        rsp_err, after_valid, after_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 0; n_rd = 0; n_wr = 0; rd_cyc = 0; wr_cyc = 0;
    wr_data = '0; wr_addr = '0; rsp_data = '0; rsp_err = 1'b0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      if (bus.mem_read)  begin n_rd++; rd_cyc = c; end
      if (bus.mem_write) begin n_wr++; wr_cyc = c; wr_data = bus.mem_wdata; wr_addr = bus.mem_addr; end
      if (bus.resp_valid) begin
        lat = c; rsp_data = bus.resp_rdata; rsp_err = bus.resp_error;
      end else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    after_valid = bus.resp_valid;
    after_ready = bus.req_ready;
  endtask

  task automatic check_txn(input string tag, input int e_lat, input logic e_err,
                           input logic [31:0] e_rdata, input int e_rd, input int e_wr);
    check({tag, ".latency"}, 32'(lat), 32'(e_lat));
    check({tag, ".error"}, {31'd0, rsp_err}, {31'd0, e_err});
    check({tag, ".rdata"}, rsp_data, e_rdata);
    check({tag, ".reads"}, 32'(n_rd), 32'(e_rd));
    check({tag, ".writes"}, 32'(n_wr), 32'(e_wr));
    check({tag, ".single_pulse"}, {31'd0, after_valid}, 32'd0);
    check({tag, ".ready_after"}, {31'd0, after_ready}, 32'd1);
  endtask

  int          n_resp, r1, r2;
  logic [31:0] d1;
  logic        rdy2, rdy3, saw_wr, saw_rv;

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    rst_n = 1'b0;

    // Reset state.
    #2;
    check("rst.req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst.strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check("rst.mem_addr", bus.mem_addr, 32'd0);
    check("rst.mem_wdata", bus.mem_wdata, 32'd0);
    check("rst.resp_rdata", bus.resp_rdata, 32'd0);
    check("rst.resp_error", {31'd0, bus.resp_error}, 32'd0);
    #10 rst_n = 1'b1;

    // sw 0x11223344 @4, then lw @4.
    txn(1'b1, 2'b10, 1'b0, 32'd4, 32'h1122_3344);
    check_txn("sw4", 2, 1'b0, 32'd0, 0, 1);
    check("sw4.wr_addr", wr_addr, 32'd4);
    check("sw4.wr_data", wr_data, 32'h1122_3344);
    check("sw4.mem", mem[1], 32'h1122_3344);
    txn(1'b0, 2'b10, 1'b0, 32'd4, 32'd0);
    check_txn("lw4", 2, 1'b0, 32'h1122_3344, 1, 0);

    // sb 0xA0 @5: RD then WR, merged word.
    txn(1'b1, 2'b00, 1'b0, 32'd5, 32'h0000_00A0);
    check_txn("sb5", 3, 1'b0, 32'd0, 1, 1);
    check("sb5.rd_cycle", 32'(rd_cyc), 32'd1);
    check("sb5.wr_cycle", 32'(wr_cyc), 32'd2);
    check("sb5.wr_addr", wr_addr, 32'd4);
    check("sb5.wr_data", wr_data, 32'h1122_A044);
    txn(1'b0, 2'b00, 1'b0, 32'd5, 32'd0);
    check_txn("lb5", 2, 1'b0, 32'hFFFF_FFA0, 1, 0);
    txn(1'b0, 2'b00, 1'b1, 32'd5, 32'd0);
    check_txn("lbu5", 2, 1'b0, 32'h0000_00A0, 1, 0);
    txn(1'b0, 2'b00, 1'b0, 32'd7, 32'd0);
    check_txn("lb7", 2, 1'b0, 32'h0000_0011, 1, 0);

    // sh 0x8001 @6 over 0x1122A044.
    txn(1'b1, 2'b01, 1'b0, 32'd6, 32'h0000_8001);
    check_txn("sh6", 3, 1'b0, 32'd0, 1, 1);
    check("sh6.wr_data", wr_data, 32'h8001_A044);
    txn(1'b0, 2'b01, 1'b0, 32'd6, 32'd0);
    check_txn("lh6", 2, 1'b0, 32'hFFFF_8001, 1, 0);
    txn(1'b0, 2'b01, 1'b1, 32'd6, 32'd0);
    check_txn("lhu6", 2, 1'b0, 32'h0000_8001, 1, 0);

    // Errors and boundaries.
    txn(1'b0, 2'b01, 1'b0, 32'd3, 32'd0);
    check_txn("lh3_err", 1, 1'b1, 32'd0, 0, 0);
    txn(1'b0, 2'b10, 1'b0, 32'd2, 32'd0);
    check_txn("lw2_err", 1, 1'b1, 32'd0, 0, 0);
    txn(1'b0, 2'b11, 1'b0, 32'd0, 32'd0);
    check_txn("size11_err", 1, 1'b1, 32'd0, 0, 0);
    txn(1'b1, 2'b11, 1'b0, 32'd0, 32'hFFFF_FFFF);
    check_txn("st_size11_err", 1, 1'b1, 32'd0, 0, 0);
    txn(1'b0, 2'b10, 1'b0, 32'd28, 32'd0);
    check_txn("lw28", 2, 1'b0, 32'd0, 1, 0);
    txn(1'b0, 2'b10, 1'b0, 32'd32, 32'd0);
    check_txn("lw32_err", 1, 1'b1, 32'd0, 0, 0);
    txn(1'b1, 2'b10, 1'b0, 32'd28, 32'hDEAD_BEEF);
    check_txn("sw28", 2, 1'b0, 32'd0, 0, 1);
    check("sw28.wr_addr", wr_addr, 32'd28);
    txn(1'b1, 2'b10, 1'b0, 32'd29, 32'h1234_5678);
    check_txn("sw29_err", 1, 1'b1, 32'd0, 0, 0);
    txn(1'b0, 2'b00, 1'b0, 32'd31, 32'd0);
    check_txn("lb31", 2, 1'b0, 32'hFFFF_FFDE, 1, 0);
    txn(1'b0, 2'b00, 1'b1, 32'd31, 32'd0);
    check_txn("lbu31", 2, 1'b0, 32'h0000_00DE, 1, 0);
    txn(1'b1, 2'b00, 1'b0, 32'd32, 32'h0000_0077);
    check_txn("sb32_err", 1, 1'b1, 32'd0, 0, 0);
    check("sb32.mem7", mem[7], 32'hDEAD_BEEF);

    // Reset during RD of sb @0.
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'h0000_0055; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rstmid.in_rd", {31'd0, bus.mem_read}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rstmid.ready", {31'd0, bus.req_ready}, 32'd1);
    check("rstmid.read_drop", {31'd0, bus.mem_read}, 32'd0);
    saw_wr = 1'b0; saw_rv = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      saw_wr |= bus.mem_write;
      saw_rv |= bus.resp_valid;
    end
    check("rstmid.no_write", {31'd0, saw_wr}, 32'd0);
    check("rstmid.no_resp", {31'd0, saw_rv}, 32'd0);
    check("rstmid.mem0", mem[0], 32'd0);

    // req_valid held high across two lw @4.
    @(negedge clk);
    bus.req_we = 1'b0; bus.req_size = 2'b10; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'd4; bus.req_wdata = 32'd0; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    n_resp = 0; r1 = 0; r2 = 0; d1 = '0; rdy2 = 1'b1; rdy3 = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      if (bus.resp_valid) begin
        n_resp++;
        if (r1 == 0) begin r1 = c; d1 = bus.resp_rdata; end
        else if (r2 == 0) r2 = c;
      end
      if (c == 2) rdy2 = bus.req_ready;
      if (c == 3) rdy3 = bus.req_ready;
      if (c == 4) bus.req_valid = 1'b0;
      if (c < 8) begin @(posedge clk); #1; end
    end
    check("hs.resp_count", 32'(n_resp), 32'd2);
    check("hs.first_resp", 32'(r1), 32'd2);
    check("hs.second_resp", 32'(r2), 32'd5);
    check("hs.ready_in_resp", {31'd0, rdy2}, 32'd0);
    check("hs.ready_after_resp", {31'd0, rdy3}, 32'd1);
    check("hs.rdata", d1, 32'h8001_A044);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
